// File: rtl/prog_counter_pkg.sv
// Shared encodings and sizing helpers for the programmable LED counter.
package prog_counter_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_UP     = 2'b00;
   localparam mode_t MODE_DOWN   = 2'b01;
   localparam mode_t MODE_BOUNCE = 2'b10;
   localparam mode_t MODE_RING   = 2'b11;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n > 32'sd1) begin
         return $clog2(n);
      end else begin
         return 32'sd1;
      end
   endfunction

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler: counts 0..DIV_N-1 and raises a registered one-clock tick the
// clock after the final count value. With DIV_N=1 the tick stays high.
module tick_gen
   import prog_counter_pkg::*;
#(
   parameter int DIV_N = 2
)
(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int PW = cnt_width(DIV_N);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV_N - 32'sd1);
   localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic          tick_q;
   logic          tick_d;
   logic          at_last;

   // Next prescaler count and tick
   always_comb begin
      at_last = (pre_q == PRE_LAST);
      if (at_last) begin
         pre_d = PRE_ZERO;
      end else begin
         pre_d = pre_q + PRE_ONE;
      end
      tick_d = at_last;
   end

   // Prescaler state
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= PRE_ZERO;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/prog_counter.sv
// WIDTH-bit LED counter with UP/DOWN/BOUNCE/RING modes, prescaled free-run,
// single-step button and parallel load. Optional step debounce: PROG_COUNTER_DEBOUNCE_EN.
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIV_N     = 2,
   parameter int DB_CYCLES = 4
)
(
   input  logic             iCLK_50,
   input  logic             iRST,
   input  logic             iEN,
   input  logic [1:0]       iMODE,
   input  logic             iSTEP,
   input  logic             iLOAD,
   input  logic [WIDTH-1:0] iLOAD_VAL,
   output logic [WIDTH-1:0] oCNT,
   output logic             oTC,
   output logic             oTICK,
   output logic             oDIR
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

   if ((WIDTH < 32'sd2) || (DIV_N < 32'sd1) || (DB_CYCLES < 32'sd1)) begin : g_param_check
      $error("prog_counter: WIDTH>=2, DIV_N>=1 and DB_CYCLES>=1 required");
   end

   logic             tick_s;
   logic [WIDTH-1:0] cnt_q,  cnt_d;
   logic             tc_q,   tc_d;
   logic             dir_q,  dir_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q,  prev_d;
   logic             step_q,  step_d;
   logic             step_lvl;
   logic             advance;
   logic [WIDTH-1:0] bounce_nxt;

   tick_gen #(
      .DIV_N (DIV_N)
   ) u_tick_gen (
      .clk  (iCLK_50),
      .rst  (iRST),
      .tick (tick_s)
   );

`ifdef PROG_COUNTER_DEBOUNCE_EN
   localparam int DB_W = cnt_width(DB_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 32'sd1);
   localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
   localparam logic [DB_W-1:0] DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            db_lvl_q, db_lvl_d;

   // Debounced level flips only after DB_CYCLES consecutive disagreeing samples
   always_comb begin
      db_cnt_d = db_cnt_q;
      db_lvl_d = db_lvl_q;
      if (sync2_q != db_lvl_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_lvl_d = sync2_q;
            db_cnt_d = DB_ZERO;
         end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
         end
      end else begin
         db_cnt_d = DB_ZERO;
      end
   end

   // Debounce state
   always_ff @(posedge iCLK_50) begin
      if (iRST) begin
         db_cnt_q <= DB_ZERO;
         db_lvl_q <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         db_lvl_q <= db_lvl_d;
      end
   end

   assign step_lvl = db_lvl_q;
`else
   assign step_lvl = sync2_q;
`endif

   // Step synchroniser and rising-edge pulse
   always_comb begin
      sync1_d = iSTEP;
      sync2_d = sync1_q;
      prev_d  = step_lvl;
      step_d  = step_lvl & ~prev_q;
   end

   assign advance = iEN ? tick_s : step_q;

   // Counter datapath: load beats advance; tc only on a qualifying advance
   always_comb begin
      cnt_d      = cnt_q;
      tc_d       = 1'b0;
      dir_d      = dir_q;
      bounce_nxt = dir_q ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
      if (iLOAD) begin
         cnt_d = iLOAD_VAL;
      end else if (advance) begin
         case (iMODE)
            MODE_UP: begin
               cnt_d = cnt_q + CNT_ONE;
               tc_d  = (cnt_q == CNT_MAX);
            end
            MODE_DOWN: begin
               cnt_d = cnt_q - CNT_ONE;
               tc_d  = (cnt_q == CNT_ZERO);
            end
            MODE_BOUNCE: begin
               cnt_d = bounce_nxt;
               if (bounce_nxt == CNT_MAX) begin
                  dir_d = 1'b1;
                  tc_d  = 1'b1;
               end else if (bounce_nxt == CNT_ZERO) begin
                  dir_d = 1'b0;
                  tc_d  = 1'b1;
               end else begin
                  dir_d = dir_q;
                  tc_d  = 1'b0;
               end
            end
            MODE_RING: begin
               // Empty ring is reseeded; any other pattern just rotates
               if (cnt_q == CNT_ZERO) begin
                  cnt_d = CNT_ONE;
                  tc_d  = 1'b0;
               end else begin
                  cnt_d = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
                  tc_d  = cnt_q[WIDTH-1];
               end
            end
            default: begin
               cnt_d = cnt_q;
               tc_d  = 1'b0;
            end
         endcase
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter, direction and step-path registers
   always_ff @(posedge iCLK_50) begin
      if (iRST) begin
         cnt_q   <= CNT_ZERO;
         tc_q    <= 1'b0;
         dir_q   <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         dir_q   <= dir_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         step_q  <= step_d;
      end
   end

   assign oCNT  = cnt_q;
   assign oTC   = tc_q;
   assign oDIR  = dir_q;
   assign oTICK = tick_s;

endmodule
